// File: rtl/iir_in_pacer.sv
// iir_in_pacer: sample FIFO that releases one held sample per pulse, pulses spaced at least GAP clocks apart
module iir_in_pacer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [17:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [17:0] out_data,
  output logic               out_valid,
  output logic [AW:0]        level,
  output logic               overflow
);
  localparam int CW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      wp, rp;
  logic signed [17:0] mem [DEPTH];
  logic               wr, rel;
  assign in_ready = level != (AW+1)'(DEPTH);
  assign wr       = in_valid && in_ready;
  assign rel      = (level != '0) && (state == S_IDLE || cnt == '0);
  // sample storage; contents need no reset since level gates every read
  always_ff @(posedge clk)
    if (wr) mem[wp] <= in_data;
  // pointers, occupancy, sticky overflow and the release pacer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rel) begin
        rp       <= rp + 1'b1;
        out_data <= mem[rp];
        state    <= S_WAIT;
        cnt      <= CW'(GAP - 1);
      end else if (cnt != '0) cnt <= cnt - 1'b1;
      else state <= S_IDLE;
      out_valid <= rel;
      level     <= level + (AW+1)'(wr) - (AW+1)'(rel);
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_iir_in_pacer.sv
// tb_iir_in_pacer: directed checks of buffering, pacing, overflow and reset behaviour
module tb_iir_in_pacer;
  localparam int DEPTH = 16, AW = 4, GAP = 7;
  logic          clk = 0, rst = 1;
  logic [17:0]   in_data = 0;
  logic          in_valid = 0;
  logic          in_ready, out_valid, overflow;
  logic [17:0]   out_data;
  logic [AW:0]   level;
  int            total = 0, bad = 0, cyc = 0;
  logic [17:0]   q_data[$];
  int            q_cyc[$];

  iir_in_pacer #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .level(level), .overflow(overflow));

  always #5 clk = ~clk;

  // log every release pulse with its cycle stamp
  always @(posedge clk) begin
    if (out_valid) begin
      q_data.push_back(out_data);
      q_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int base, herr, peak, n;
    #2 rst = 0;
    in_valid = 1;
    in_data  = 18'h12345;
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    in_valid = 0;
    rst = 1;
    base = q_data.size();
    repeat (20) @(negedge clk);
    check("idle_pulses", q_data.size() - base, 0);
    check("idle_level", level, 0);

    base = q_data.size();
    in_data = 18'h1F000; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check("single_level1", level, 1);
    check("single_early", out_valid, 0);
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 18'h1F000);
    check("single_level0", level, 0);
    herr = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_data !== 18'h1F000) herr++;
    end
    check("single_hold", herr, 0);
    check("single_pulses", q_data.size() - base, 1);

    base = q_data.size();
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      in_data = 18'(i); in_valid = 1;
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    in_valid = 0;
    repeat (45) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    n = q_data.size() - base;
    check("burst_count", n, 5);
    check("burst_peak", peak, 4);
    for (int i = 0; i < n && i < 5; i++) begin
      check("burst_data", q_data[base+i], 18'(i + 1));
      if (i > 0) check("burst_gap", q_cyc[base+i] - q_cyc[base+i-1], GAP);
    end

    base = q_data.size();
    for (int i = 0; i < 22; i++) begin
      in_data = 18'h100 + 18'(i); in_valid = 1;
      @(negedge clk);
      if (i == 17) begin
        check("full_lvl15", level, 15);
        check("full_rdy15", in_ready, 1);
      end
      if (i == 18) begin
        check("full_lvl16", level, 16);
        check("full_rdy16", in_ready, 0);
        check("full_ovf_pre", overflow, 0);
      end
      if (i == 19) check("full_ovf", overflow, 1);
    end
    in_valid = 0;
    repeat (130) @(negedge clk);
    n = q_data.size() - base;
    check("full_count", n, 19);
    for (int i = 0; i < n && i < 19; i++) check("full_data", q_data[base+i], 18'h100 + 18'(i));
    check("full_drained", level, 0);
    check("full_ovf_sticky", overflow, 1);

    for (int i = 0; i < 7; i++) begin
      in_data = 18'h50 + 18'(i); in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    check("mid_level6", level, 6);
    rst = 0;
    #1;
    check("mid_level", level, 0);
    check("mid_valid", out_valid, 0);
    check("mid_ovf", overflow, 0);
    check("mid_rdy", in_ready, 1);
    @(negedge clk);
    rst = 1;
    base = q_data.size();
    in_data = 18'h3ABCD; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check("mid_post_lvl", level, 1);
    check("mid_post_early", out_valid, 0);
    @(negedge clk);
    check("mid_post_valid", out_valid, 1);
    check("mid_post_data", out_data, 18'h3ABCD);
    repeat (20) @(negedge clk);
    check("mid_post_pulses", q_data.size() - base, 1);

    base = q_data.size();
    for (int k = 0; k < 4; k++) begin
      in_data = 18'h2000 + 18'(k); in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    check("sim_level_start", level, 3);
    repeat (4) @(negedge clk);
    for (int k = 4; k < 40; k++) begin
      in_data = 18'h2000 + 18'(k); in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      check("sim_level", level, 3);
      check("sim_release", out_valid, 1);
      if (k < 39) repeat (6) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    n = q_data.size() - base;
    check("sim_count", n, 40);
    for (int i = 0; i < n && i < 40; i++) check("sim_data", q_data[base+i], 18'h2000 + 18'(i));
    check("sim_drained", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
